phrase_ram_ctrl: RTL
====================

# phrase_ram_ctrl

Write sequencer and read front-end for the 8192×8 phrase RAM (negedge-sampled, separate read and write addresses, shared enable) in the phrase module of the console. Serialises two write sources onto the single RAM write port: a byte-stream phrase loader and a fill engine for clearing or painting regions. Passes display read requests through every cycle with fixed latency. Optionally zero-initialises the whole RAM after reset.

## Interface
- ADDR_W, 13, RAM address width (depth 2^ADDR_W)
- DATA_W, 8, RAM data width
- LEN_W, 7, phrase length width (0..127 bytes)
- clock  in  1  system clock; all control registers update on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ld_start  in  1  start phrase load (sampled in IDLE only)
- ld_base  in  ADDR_W  first address of phrase
- ld_len  in  LEN_W  byte count
- ld_byte  in  DATA_W  phrase byte
- ld_valid  in  1  ld_byte valid
- ld_ready  out  1  controller accepts ld_byte this cycle
- fill_start  in  1  start fill (sampled in IDLE only)
- fill_base  in  ADDR_W  first fill address
- fill_len  in  ADDR_W+1  fill count (0..8192)
- fill_byte  in  DATA_W  fill value
- wr_busy  out  1  write sequencer not in IDLE
- wr_done  out  1  one-cycle pulse at end of load/fill
- rd_req  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_valid  out  1  rd_data valid (one-cycle pulse)
- rd_data  out  DATA_W  read data
- ram_en, ram_we  out  1  RAM enable_ram / write_enable
- ram_addr_wr, ram_addr_rd  out  ADDR_W  RAM addresses
- ram_din  out  DATA_W  RAM data_in
- ram_dout  in  DATA_W  RAM data_out

## Operation
- States: CLEAR, IDLE, LOAD, FILL. All RAM-side outputs registered.
- IDLE: ld_start has priority over fill_start in the same cycle; the loser is dropped (requester checks wr_busy). Starts while busy are ignored.
- LOAD: latch base, len; ld_ready=1 while remaining>0; each ld_valid&&ld_ready edge drives ram_we=1, ram_addr_wr=base+offset, ram_din=ld_byte, offset++. After last byte -> IDLE, wr_done.
- FILL: one write per cycle of fill_byte to base+offset, fill_len cycles, no handshake -> IDLE, wr_done.
- Length 0 (load or fill): no writes, wr_done next cycle, stays IDLE.
- Address arithmetic modulo 2^ADDR_W: base+offset wraps 8191->0.
- Read path independent of FSM: every rd_req cycle drives ram_addr_rd=rd_addr. Read and write in the same cycle both proceed; same address returns the old byte (read-before-write).
- ram_en = write active OR rd_req (registered); ram_we only with write active.
- Reset (any state): all outputs 0, transfer aborted, partial data remains in RAM, no further writes.

## Timing
- Reset values: ld_ready=0, wr_busy=0 (1 with CLEAR_ON_RESET), wr_done=0, rd_valid=0, rd_data=0, all ram_* =0.
- Write: RAM signals registered at acceptance edge k; RAM writes at negedge k+½.
- Read: rd_req sampled at edge k; RAM reads at negedge k+½; rd_data<=ram_dout and rd_valid=1 at edge k+1, for one cycle. Back-to-back reads give one result per cycle.
- Load throughput: 1 byte/cycle with ld_valid held high. wr_done rises at the edge after last acceptance; wr_busy falls on the same edge.
- Fill of N bytes: wr_busy high N cycles, wr_done at edge N+1 after start.

## Configuration
- PHRASE_CLEAR_ON_RESET_EN defined: reset enters CLEAR; writes 0 to addresses 0..8191, one per cycle (8192 cycles), wr_busy=1, ld/fill starts ignored, reads serviced; then IDLE with no wr_done pulse.
- Undefined: reset enters IDLE; RAM contents untouched.

## Structure
- Package phrase_ram_pkg: ADDR_W, DATA_W, LEN_W, MEM_DEPTH=8192, state enum (CLEAR, IDLE, LOAD, FILL).
- Sub-module phrase_ram_addr_gen: base register plus wrapping offset counter with remaining-count/last flag, shared by LOAD, FILL and CLEAR.

## Test plan
- Load base=0x0010, len=3, bytes 0x41,0x42,0x43, ld_valid stalled 1 cycle -> RAM[0x10..0x12]=41,42,43; wr_done one pulse; ld_ready low after 3rd byte.
- Load base=0x1FFF, len=2 -> RAM[0x1FFF]=first byte, RAM[0x0000]=second (wrap).
- Fill base=0x0100, len=0x40, byte=0x20, with rd_req to 0x0100 every cycle -> first rd_data is old value, 0x20 after the write; wr_busy exactly 64 cycles.
- ld_start and fill_start same IDLE cycle -> load runs, fill dropped; fill_start during LOAD ignored; len=0 -> wr_done next cycle, ram_we never high.
- reset_n low mid-fill (offset 5 of 20) -> all outputs 0 immediately; only 5 bytes written; fresh load succeeds after release.
- With PHRASE_CLEAR_ON_RESET_EN after RAM preloaded with 0xFF: wr_busy high 8192 cycles, reads of 0x0000 and 0x1FFF then return 0x00.

Source files
------------

// File: rtl/phrase_ram_pkg.sv
// Shared constants and types for the phrase RAM write sequencer and read front-end.
// Optional feature macro: PHRASE_CLEAR_ON_RESET_EN (zero-fill of the whole RAM after reset).
package phrase_ram_pkg;

    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 8;
    localparam int LEN_W     = 7;
    localparam int MEM_DEPTH = 1 << ADDR_W;
    // Counter width able to hold MEM_DEPTH itself (a full-RAM fill or clear).
    localparam int CNT_W     = ADDR_W + 1;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        LOAD,
        FILL
    } wr_state_t;

endpackage

// File: rtl/phrase_ram_addr_gen.sv
// Write address generator: base register plus a wrapping offset counter and a
// remaining-byte count. Shared by phrase load, fill and post-reset clear.
module phrase_ram_addr_gen
    import phrase_ram_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_REMAIN = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [CNT_W-1:0]  load_len,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] offset;
    logic [CNT_W-1:0]  remain;

    // Load a new transfer, or advance one byte per issued write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base   <= '0;
            offset <= '0;
            remain <= RST_REMAIN;
        end else if (load) begin
            base   <= load_base;
            offset <= '0;
            remain <= load_len;
        end else if (step && (remain != '0)) begin
            offset <= offset + ADDR_W'(1);
            remain <= remain - CNT_W'(1);
        end
    end

    // Sum truncates to ADDR_W bits, so 8191 + 1 wraps to address 0.
    assign addr = base + offset;
    assign last = (remain == CNT_W'(1));

endmodule

// File: rtl/phrase_ram_ctrl.sv
// Phrase RAM controller: serialises the phrase loader and the fill engine onto
// the single RAM write port and passes display reads through with fixed latency.
// Optional feature macro: PHRASE_CLEAR_ON_RESET_EN -- when defined, reset enters
// CLEAR and zero-fills every address before accepting loads or fills.
module phrase_ram_ctrl
    import phrase_ram_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ld_start,
    input  logic [ADDR_W-1:0]   ld_base,
    input  logic [LEN_W-1:0]    ld_len,
    input  logic [DATA_W-1:0]   ld_byte,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic                fill_start,
    input  logic [ADDR_W-1:0]   fill_base,
    input  logic [ADDR_W:0]     fill_len,
    input  logic [DATA_W-1:0]   fill_byte,
    output logic                wr_busy,
    output logic                wr_done,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr_wr,
    output logic [ADDR_W-1:0]   ram_addr_rd,
    output logic [DATA_W-1:0]   ram_din,
    input  logic [DATA_W-1:0]   ram_dout
);

`ifdef PHRASE_CLEAR_ON_RESET_EN
    localparam wr_state_t        RST_STATE  = CLEAR;
    localparam logic [CNT_W-1:0] RST_REMAIN = CNT_W'(MEM_DEPTH);
`else
    localparam wr_state_t        RST_STATE  = IDLE;
    localparam logic [CNT_W-1:0] RST_REMAIN = '0;
`endif

    wr_state_t         state;
    logic              ld_go;
    logic              fill_go;
    logic              wr_fire;
    logic              ag_load;
    logic              ag_last;
    logic [ADDR_W-1:0] ag_base;
    logic [CNT_W-1:0]  ag_len;
    logic [ADDR_W-1:0] ag_addr;
    logic [DATA_W-1:0] fill_val;
    logic              rd_vld_p1;

    // Load wins over fill when both start in the same IDLE cycle.
    assign ld_go   = (state == IDLE) && ld_start;
    assign fill_go = (state == IDLE) && !ld_start && fill_start;
    assign ag_base = ld_go ? ld_base : fill_base;
    assign ag_len  = ld_go ? CNT_W'(ld_len) : fill_len;
    assign ag_load = (ld_go || fill_go) && (ag_len != '0);

    // A RAM write is issued this cycle.
    assign wr_fire = (state == CLEAR) || (state == FILL) || ((state == LOAD) && ld_valid);

    // LOAD is only ever occupied while bytes remain, so ready follows the state.
    assign ld_ready = (state == LOAD);
    assign wr_busy  = (state != IDLE);

    phrase_ram_addr_gen #(
        .RST_REMAIN (RST_REMAIN)
    ) u_addr_gen (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (ag_load),
        .load_base (ag_base),
        .load_len  (ag_len),
        .step      (wr_fire),
        .addr      (ag_addr),
        .last      (ag_last)
    );

    // Fill value is captured at start so the requester may change fill_byte afterwards.
    always_ff @(posedge clock) begin
        if (fill_go) begin
            fill_val <= fill_byte;
        end
    end

    // Write sequencer FSM with registered RAM write-side outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RST_STATE;
            wr_done     <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr_wr <= '0;
            ram_din     <= '0;
        end else begin
            wr_done <= 1'b0;
            ram_we  <= wr_fire;
            case (state)
                CLEAR: begin
                    ram_addr_wr <= ag_addr;
                    ram_din     <= '0;
                    if (ag_last) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (ld_go || fill_go) begin
                        if (ag_len == '0) begin
                            wr_done <= 1'b1;
                        end else begin
                            state <= ld_go ? LOAD : FILL;
                        end
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        ram_addr_wr <= ag_addr;
                        ram_din     <= ld_byte;
                        if (ag_last) begin
                            state   <= IDLE;
                            wr_done <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    ram_addr_wr <= ag_addr;
                    ram_din     <= fill_val;
                    if (ag_last) begin
                        state   <= IDLE;
                        wr_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read front-end: address out on the request edge, data captured one edge later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_en      <= 1'b0;
            ram_addr_rd <= '0;
            rd_vld_p1   <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            ram_en    <= wr_fire || rd_req;
            rd_vld_p1 <= rd_req;
            rd_valid  <= rd_vld_p1;
            if (rd_req) begin
                ram_addr_rd <= rd_addr;
            end
            if (rd_vld_p1) begin
                rd_data <= ram_dout;
            end
        end
    end

endmodule
